// File: rtl/thread_state_ctrl_pkg.sv
// Shared encodings for the thread-state table: state values, requester indices,
// control FSM states and the legal-predecessor rule used by the transition check.
package thread_state_ctrl_pkg;

  localparam int THREAD_STATE_W   = 2;
  localparam int THREAD_STATE_MSB = THREAD_STATE_W - 1;

  typedef enum logic [THREAD_STATE_MSB:0] {
    TS_NONE   = 2'd0,
    TS_WR_RDY = 2'd1,
    TS_BUSY   = 2'd2,
    TS_RD_RDY = 2'd3
  } thread_state_e;

  localparam int TS_REQ_CPU      = 0;
  localparam int TS_REQ_CORE_IN  = 1;
  localparam int TS_REQ_CORE_OUT = 2;
  localparam int N_REQ           = 3;

  typedef enum logic {
    CTRL_INIT = 1'b0,
    CTRL_RUN  = 1'b1
  } ctrl_state_e;

  // Index of the highest set bit; 0 for values 0 and 1.
  function automatic int msb(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((v >> i) != 0) r = i;
    end
    return r;
  endfunction

  function automatic logic ts_legal(input logic [THREAD_STATE_MSB:0] old_s,
                                    input logic [THREAD_STATE_MSB:0] new_s);
    case (new_s)
      TS_WR_RDY: return (old_s == TS_NONE) || (old_s == TS_RD_RDY);
      TS_BUSY:   return (old_s == TS_WR_RDY);
      TS_RD_RDY: return (old_s == TS_BUSY);
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ts_wr_arbiter.sv
// Three-way round-robin arbiter: picks the first asserted request starting at ptr_i,
// wrapping 2->0, and returns the pointer just past the winner (held if idle).
module ts_wr_arbiter
  import thread_state_ctrl_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [1:0]       ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [1:0]       ptr_next_o
);

  logic [1:0] cand [N_REQ];

  // cand[k] is the requester examined k-th in priority order.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [2:0] sum;
    assign sum      = {1'b0, ptr_i} + 3'(gi);
    assign cand[gi] = (sum >= 3'(N_REQ)) ? 2'(sum - 3'(N_REQ)) : sum[1:0];
  end

  always_comb begin
    gnt_o      = '0;
    ptr_next_o = ptr_i;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_i[cand[k]]) begin
        gnt_o          = '0;
        gnt_o[cand[k]] = 1'b1;
        ptr_next_o     = (cand[k] == 2'(N_REQ - 1)) ? 2'd0 : cand[k] + 2'd1;
      end
    end
  end

endmodule

// File: rtl/thread_state_ctrl.sv
// Per-thread state table: clears itself after reset, then commits one arbitrated write per cycle.
// Build option: define THREAD_STATE_CHECK_EN to flag illegal state transitions on ts_err.
module thread_state_ctrl
  import thread_state_ctrl_pkg::*;
#(
  parameter int N_CORES       = 4,
  parameter int N_THREADS     = 16,
  parameter int N_THREADS_MSB = msb(N_THREADS - 1)
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [2:0]                  wr_req,
  input  logic [N_THREADS_MSB:0]      wr_num0,
  input  logic [N_THREADS_MSB:0]      wr_num1,
  input  logic [N_THREADS_MSB:0]      wr_num2,
  input  logic [THREAD_STATE_MSB:0]   wr_state0,
  input  logic [THREAD_STATE_MSB:0]   wr_state1,
  input  logic [THREAD_STATE_MSB:0]   wr_state2,
  output logic [2:0]                  wr_ack,
  input  logic [N_THREADS_MSB:0]      ts_rd_num,
  output logic [THREAD_STATE_MSB:0]   ts_rd,
  input  logic [N_THREADS_MSB:0]      cpu_rd_num,
  output logic [THREAD_STATE_MSB:0]   cpu_rd,
  output logic                        init_done,
  output logic                        ts_err
);

  // Degenerate configurations never clear or accept writes.
  localparam bit CFG_OK = (N_CORES > 0) && (N_THREADS > 1);
  localparam logic [N_THREADS_MSB:0] INIT_LAST = (N_THREADS_MSB + 1)'(N_THREADS - 1);

  ctrl_state_e                 state_q;
  logic [N_THREADS_MSB:0]      init_cnt_q;
  logic [1:0]                  rr_ptr_q;
  logic [1:0]                  rr_ptr_d;
  logic                        init_done_q;
  logic [N_REQ-1:0]            gnt;
  logic [N_THREADS_MSB:0]      req_num   [N_REQ];
  logic [THREAD_STATE_MSB:0]   req_state [N_REQ];
  logic [N_THREADS_MSB:0]      sel_num;
  logic [THREAD_STATE_MSB:0]   sel_state;
  logic                        run_wr;
  logic                        tbl_we;
  logic [N_THREADS_MSB:0]      tbl_waddr;
  logic [THREAD_STATE_MSB:0]   tbl_wdata;
  logic [THREAD_STATE_MSB:0]   tbl_q [N_THREADS];

  assign req_num[TS_REQ_CPU]        = wr_num0;
  assign req_num[TS_REQ_CORE_IN]    = wr_num1;
  assign req_num[TS_REQ_CORE_OUT]   = wr_num2;
  assign req_state[TS_REQ_CPU]      = wr_state0;
  assign req_state[TS_REQ_CORE_IN]  = wr_state1;
  assign req_state[TS_REQ_CORE_OUT] = wr_state2;

  ts_wr_arbiter u_arb (
    .req_i      (wr_req),
    .ptr_i      (rr_ptr_q),
    .gnt_o      (gnt),
    .ptr_next_o (rr_ptr_d)
  );

  // Gating on RST_N drops a pending request during the reset cycle itself.
  assign wr_ack = (RST_N && (state_q == CTRL_RUN)) ? gnt : '0;

  always_comb begin
    sel_num   = req_num[0];
    sel_state = req_state[0];
    for (int k = 1; k < N_REQ; k++) begin
      if (gnt[k]) begin
        sel_num   = req_num[k];
        sel_state = req_state[k];
      end
    end
  end

  // Out-of-range indices are still acked but never reach the table.
  assign run_wr = (|wr_ack) && (int'(sel_num) < N_THREADS);

  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = init_cnt_q;
    tbl_wdata = TS_NONE;
    if (RST_N && CFG_OK) begin
      if (state_q == CTRL_INIT) begin
        tbl_we = 1'b1;
      end else if (run_wr) begin
        tbl_we    = 1'b1;
        tbl_waddr = sel_num;
        tbl_wdata = sel_state;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (tbl_we) tbl_q[tbl_waddr] <= tbl_wdata;
  end

  assign ts_rd  = tbl_q[ts_rd_num];
  assign cpu_rd = tbl_q[cpu_rd_num];

`ifdef THREAD_STATE_CHECK_EN
  logic ts_err_q;
  logic bad_wr;
  // Compared against the pre-write value; the write commits regardless.
  assign bad_wr = run_wr && !ts_legal(tbl_q[sel_num], sel_state);
  assign ts_err = ts_err_q;
`else
  assign ts_err = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= CTRL_INIT;
      init_cnt_q  <= '0;
      rr_ptr_q    <= 2'd0;
      init_done_q <= 1'b0;
`ifdef THREAD_STATE_CHECK_EN
      ts_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        CTRL_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == INIT_LAST) begin
            state_q     <= CTRL_RUN;
            init_done_q <= 1'b1;
          end
        end
        CTRL_RUN: begin
          rr_ptr_q <= rr_ptr_d;
`ifdef THREAD_STATE_CHECK_EN
          if (bad_wr) ts_err_q <= 1'b1;
`endif
        end
        default: state_q <= CTRL_INIT;
      endcase
    end
  end

  assign init_done = init_done_q;

endmodule

// File: tb/tb_thread_state_ctrl.sv
// Bench for thread_state_ctrl: requester stimulus feeds a queue of expected responses
// from a behavioural table/arbitration model; a negedge monitor pops and compares.
module tb_thread_state_ctrl;
  import thread_state_ctrl_pkg::*;

  localparam int NT = 16;
`ifdef THREAD_STATE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [2:0] wr_req = '0;
  logic [3:0] wr_num0 = '0, wr_num1 = '0, wr_num2 = '0;
  logic [1:0] wr_state0 = '0, wr_state1 = '0, wr_state2 = '0;
  logic [2:0] wr_ack;
  logic [3:0] ts_rd_num = '0, cpu_rd_num = '0;
  logic [1:0] ts_rd, cpu_rd;
  logic       init_done, ts_err;

  always #5 CLK = ~CLK;

  thread_state_ctrl dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .wr_req     (wr_req),
    .wr_num0    (wr_num0),
    .wr_num1    (wr_num1),
    .wr_num2    (wr_num2),
    .wr_state0  (wr_state0),
    .wr_state1  (wr_state1),
    .wr_state2  (wr_state2),
    .wr_ack     (wr_ack),
    .ts_rd_num  (ts_rd_num),
    .ts_rd      (ts_rd),
    .cpu_rd_num (cpu_rd_num),
    .cpu_rd     (cpu_rd),
    .init_done  (init_done),
    .ts_err     (ts_err)
  );

  typedef struct {
    logic [2:0] ack;
    logic [1:0] ts;
    logic [1:0] cpu;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // Requester-side view and reference model state.
  bit         pend [3];
  logic [3:0] pnum [3];
  logic [1:0] pst  [3];
  logic [1:0] m_tab [NT];
  int         m_ptr;
  bit         m_err;
  int         rd_ts, rd_cpu;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic bit pred_ok(input logic [1:0] old_s, input logic [1:0] new_s);
    if (new_s == TS_NONE)   return 1'b1;
    if (new_s == TS_WR_RDY) return (old_s == TS_NONE) || (old_s == TS_RD_RDY);
    if (new_s == TS_BUSY)   return old_s == TS_WR_RDY;
    return old_s == TS_BUSY;
  endfunction

  task automatic drive();
    wr_req     = {pend[2], pend[1], pend[0]};
    wr_num0    = pnum[0];
    wr_num1    = pnum[1];
    wr_num2    = pnum[2];
    wr_state0  = pst[0];
    wr_state1  = pst[1];
    wr_state2  = pst[2];
    ts_rd_num  = 4'(rd_ts);
    cpu_rd_num = 4'(rd_cpu);
  endtask

  // One RUN cycle: called at posedge+1, returns at the next posedge+1.
  task automatic step();
    exp_t e;
    int   g;
    drive();
    g = -1;
    for (int k = 0; k < 3; k++) begin
      if (g < 0 && pend[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
    end
    e.ack = (g < 0) ? 3'b000 : 3'(1 << g);
    e.ts  = m_tab[rd_ts];
    e.cpu = m_tab[rd_cpu];
    e.err = m_err;
    sb_q.push_back(e);
    if (g >= 0) begin
      if (CHK && !pred_ok(m_tab[pnum[g]], pst[g])) m_err = 1'b1;
      m_tab[pnum[g]] = pst[g];
      m_ptr   = (g + 1) % 3;
      pend[g] = 1'b0;
    end
    @(posedge CLK); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((pend[0] || pend[1] || pend[2]) && n < 6) begin
      step();
      n++;
    end
    chk("drain_bound", int'(pend[0] || pend[1] || pend[2]), 0);
  endtask

  // Reset with the current requests held, then wait out table clearing.
  task automatic do_reset();
    int cnt;
    drive();
    RST_N = 1'b0;
    #2;
    chk("rst_ack", int'(wr_ack), 0);
    @(posedge CLK); #1;
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_ts_err", int'(ts_err), 0);
    RST_N = 1'b1;
    cnt = 0;
    while (init_done !== 1'b1 && cnt < 40) begin
      chk("init_ack", int'(wr_ack), 0);
      @(posedge CLK); #1;
      cnt++;
    end
    chk("init_len", cnt, NT);
    for (int i = 0; i < NT; i++) m_tab[i] = TS_NONE;
    m_ptr = 0;
    m_err = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      $display("txn t=%0t req=%b ack=%b ts_rd[%0d]=%0d cpu_rd[%0d]=%0d ts_err=%0b",
               $time, wr_req, wr_ack, ts_rd_num, ts_rd, cpu_rd_num, cpu_rd, ts_err);
      chk("wr_ack", int'(wr_ack), int'(mon_e.ack));
      chk("ts_rd", int'(ts_rd), int'(mon_e.ts));
      chk("cpu_rd", int'(cpu_rd), int'(mon_e.cpu));
      chk("ts_err", int'(ts_err), int'(mon_e.err));
    end
  end

  initial begin
    for (int r = 0; r < 3; r++) begin
      pend[r] = 1'b0;
      pnum[r] = '0;
      pst[r]  = TS_NONE;
    end
    for (int i = 0; i < NT; i++) m_tab[i] = TS_NONE;
    m_ptr = 0; m_err = 1'b0; rd_ts = 0; rd_cpu = 0;
    @(posedge CLK); #1;

    // All three requesters held through INIT, writing NONE.
    for (int r = 0; r < 3; r++) begin
      pend[r] = 1'b1;
      pnum[r] = 4'(r + 1);
      pst[r]  = TS_NONE;
    end
    do_reset();

    // Saturated round-robin: 001, 010, 100, 001.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 3; r++) pend[r] = 1'b1;
      step();
    end
    drain();

    // Every entry reads NONE on both ports.
    for (int i = 0; i < NT; i++) begin
      rd_ts = i; rd_cpu = NT - 1 - i;
      step();
    end

    // Each requester alone; read back the following cycle.
    for (int r = 0; r < 3; r++) begin
      pend[r] = 1'b1; pnum[r] = 4'(5 + 4 * r); pst[r] = TS_WR_RDY;
      rd_ts = 5 + 4 * r; rd_cpu = 5 + 4 * r;
      step();
      step();
    end

    // Same-cycle read of the entry being written sees the old value.
    pend[1] = 1'b1; pnum[1] = 4'd3; pst[1] = TS_WR_RDY;
    rd_ts = 3; rd_cpu = 3;
    step();
    step();

    // Illegal NONE -> BUSY on thread 7; flag stays set in checking builds.
    pend[0] = 1'b1; pnum[0] = 4'd7; pst[0] = TS_BUSY;
    rd_ts = 7; rd_cpu = 7;
    step();
    step();
    step();

    for (int c = 0; c < 300; c++) begin
      for (int r = 0; r < 3; r++) begin
        if (!pend[r] && ($urandom_range(1, 0) == 1)) begin
          pend[r] = 1'b1;
          pnum[r] = 4'($urandom_range(NT - 1, 0));
          pst[r]  = 2'($urandom_range(3, 0));
        end
      end
      rd_ts  = int'($urandom_range(NT - 1, 0));
      rd_cpu = int'($urandom_range(NT - 1, 0));
      step();
    end
    drain();

    // Reset while core_out is pending: dropped, then granted on the first RUN cycle.
    pend[2] = 1'b1; pnum[2] = 4'd9; pst[2] = TS_WR_RDY;
    rd_ts = 9; rd_cpu = 0;
    do_reset();
    step();
    step();

    @(negedge CLK); #1;
    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
